// File: rtl/rr_encoder_arbiter_pkg.sv
// rr_encoder_arbiter_pkg: shared sizes, state encoding and default timeout for the round-robin arbiter
package rr_encoder_arbiter_pkg;
    localparam int NREQ        = 8;
    localparam int CODE_W      = 3;
    localparam int TIMEOUT_DEF = 16;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_encoder_arbiter_prio_enc8.sv
// rr_prio_enc8: combinational round-robin priority encoder (lowest req index >= ptr, else lowest overall)
//   req      in  [7:0] request vector
//   ptr      in  [2:0] priority pointer
//   win_oh   out [7:0] one-hot winner, zero when no request
//   win_code out [2:0] binary winner index, zero when no request
//   any_req  out       at least one request present
module rr_prio_enc8
    import rr_encoder_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]   req,
    input  logic [CODE_W-1:0] ptr,
    output logic [NREQ-1:0]   win_oh,
    output logic [CODE_W-1:0] win_code,
    output logic              any_req
);
    logic [NREQ-1:0]   masked;
    logic [CODE_W-1:0] code_m;
    logic [CODE_W-1:0] code_u;
    always_comb begin
        masked = '0;
        code_m = '0;
        code_u = '0;
        // descending scan leaves the lowest matching index in each pass
        for (int i = NREQ - 1; i >= 0; i--) begin
            masked[i] = req[i] && (i >= int'(ptr));
            code_u    = req[i] ? CODE_W'(i) : code_u;
            code_m    = masked[i] ? CODE_W'(i) : code_m;
        end
        any_req  = |req;
        win_code = (|masked) ? code_m : code_u;
        win_oh   = any_req ? ({{(NREQ-1){1'b0}}, 1'b1} << win_code) : '0;
    end
endmodule

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter: 8-way round-robin arbiter returning grants as one-hot and 3-bit binary code
//   clk       in        rising-edge clock
//   rst       in        asynchronous active-high reset
//   req       in  [7:0] request vector
//   done      in        release pulse from the current owner
//   gnt       out [7:0] registered one-hot grant, zero when idle
//   gnt_code  out [2:0] registered binary grant index, zero when idle
//   gnt_valid out       high while a grant is held
//   timeout   out       one-cycle pulse on forced release (ARB_TIMEOUT_EN), else constant 0
// Define ARB_TIMEOUT_EN to force-release a grant held for TIMEOUT cycles.
module rr_encoder_arbiter
    import rr_encoder_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              done,
    output logic [NREQ-1:0]   gnt,
    output logic [CODE_W-1:0] gnt_code,
    output logic              gnt_valid,
    output logic              timeout
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be within 2..255");
    end
    state_t            state_q, state_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [NREQ-1:0]   win_oh;
    logic [CODE_W-1:0] win_code;
    logic              any_req;
    logic              rel;
    logic              expire;
    rr_prio_enc8 u_enc (
        .req      (req),
        .ptr      (ptr_q),
        .win_oh   (win_oh),
        .win_code (win_code),
        .any_req  (any_req)
    );
    // done and a dropped owner request collapse into one release
    assign rel = done || !req[code_q];
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    assign expire = (cnt_q == 8'(TIMEOUT - 1));
    always_comb begin
        cnt_d     = (state_q == ST_GRANT) ? cnt_q + 8'd1 : 8'd0;
        timeout_d = (state_q == ST_GRANT) && !rel && expire;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        if (state_q == ST_IDLE) begin
            if (any_req) begin
                state_d = ST_GRANT;
                gnt_d   = win_oh;
                code_d  = win_code;
                valid_d = 1'b1;
            end
        end else if (rel || expire) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            code_d  = '0;
            valid_d = 1'b0;
            ptr_d   = code_q + CODE_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_code  = code_q;
    assign gnt_valid = valid_q;
endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// tb_rr_encoder_arbiter: directed scoreboard bench for rr_encoder_arbiter
module tb_rr_encoder_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_code;
    logic       gnt_valid;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];

    rr_encoder_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_code  (gnt_code),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!gnt_valid && cyc < 20);
    endtask

    task automatic release_done(input logic [7:0] next_req);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = next_req;
        chk("release_valid", int'(gnt_valid), 0);
        chk("release_gnt", int'(gnt), 0);
    endtask

    // monitor: every new grant is compared against the next expected code
    initial begin
        logic       pv;
        int         e;
        logic [7:0] oh;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got code %0d expected none", gnt_code);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 8'd1;
                    oh = oh << e;
                    chk("grant_code", int'(gnt_code), e);
                    chk("grant_onehot", int'(gnt), int'(oh));
                end
            end
            pv = gnt_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int held;
        int to_seen;
        repeat (2) @(negedge clk);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_code", int'(gnt_code), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
        // async reset mid-grant
        req = 8'b0001_0000;
        exp_q.push_back(4);
        wait_grant(cyc);
        chk("latency_4", cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_code", int'(gnt_code), 0);
        chk("async_valid", int'(gnt_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'b0000_0001;
        exp_q.push_back(0);
        wait_grant(cyc);
        chk("latency_0", cyc, 1);
        release_done(8'h00);
        // rotation with ptr=1: 7,0,7,0
        req = 8'b1000_0001;
        exp_q.push_back(7);
        exp_q.push_back(0);
        exp_q.push_back(7);
        exp_q.push_back(0);
        for (int k = 0; k < 4; k++) begin
            wait_grant(cyc);
            chk("rot_latency", cyc, 1);
            release_done(k == 3 ? 8'h00 : 8'b1000_0001);
        end
        // wrap search: release 4 -> ptr=5, req bit 2 only -> 2
        req = 8'b0001_0000;
        exp_q.push_back(4);
        wait_grant(cyc);
        release_done(8'b0000_0100);
        exp_q.push_back(2);
        wait_grant(cyc);
        chk("wrap_latency", cyc, 1);
        release_done(8'hFF);
        for (int k = 0; k < 8; k++) exp_q.push_back((3 + k) % 8);
        for (int k = 0; k < 8; k++) begin
            wait_grant(cyc);
            chk("all_latency", cyc, 1);
            release_done(k == 7 ? 8'h00 : 8'hFF);
        end
        // hold ignores other bits, then request drop with req[6] waiting
        req = 8'b0000_1000;
        exp_q.push_back(3);
        wait_grant(cyc);
        req = 8'b1111_1001;
        repeat (3) begin
            @(negedge clk);
            chk("hold_code", int'(gnt_code), 3);
            chk("hold_valid", int'(gnt_valid), 1);
        end
        req = 8'b0100_0000;
        @(negedge clk);
        chk("drop_valid", int'(gnt_valid), 0);
        chk("drop_gnt", int'(gnt), 0);
        exp_q.push_back(6);
        wait_grant(cyc);
        chk("drop_latency", cyc, 1);
        release_done(8'h00);
        // done in IDLE ignored; ptr=7 wraps to 0
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("idle_done", int'(gnt_valid), 0);
        req = 8'b0000_0001;
        exp_q.push_back(0);
        wait_grant(cyc);
        release_done(8'h00);
        // simultaneous done and drop -> single release, ptr=2
        req = 8'b0000_0010;
        exp_q.push_back(1);
        wait_grant(cyc);
        done = 1'b1;
        req  = 8'h00;
        @(negedge clk);
        done = 1'b0;
        chk("both_rel", int'(gnt_valid), 0);
        @(negedge clk);
        chk("both_idle", int'(gnt_valid), 0);
        // long hold
        req = 8'b0001_0000;
        exp_q.push_back(4);
        wait_grant(cyc);
        held    = 1;
        to_seen = 0;
        for (int i = 0; i < 110 && gnt_valid; i++) begin
            @(negedge clk);
            if (timeout) to_seen++;
            if (gnt_valid) held++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_held", held, 16);
        chk("to_pulse", int'(timeout), 1);
        chk("to_count", to_seen, 1);
        req = 8'b0010_0001;
        exp_q.push_back(5);
        wait_grant(cyc);
        chk("to_clear", int'(timeout), 0);
`else
        chk("hold_long", held, 111);
        chk("no_timeout", to_seen, 0);
        release_done(8'b0010_0001);
        exp_q.push_back(5);
        wait_grant(cyc);
`endif
        chk("after_hold_latency", cyc, 1);
        release_done(8'h00);
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
